spi_cmd_controller: RTL and testbench

SPI mode-0 controller: the initiating end of the register-write SPI link that configures the PWM peripheral's enable and duty-cycle registers. It accepts one command at a time over a valid/ready port and serialises it as a 16-bit frame on SCLK/COPI/nCS. On a read it captures 8 bits from CIPO. It sits in test harnesses and in any on-chip host that must program the PWM register bank over its SPI pins.

---
 rtl/spi_ctrl_pkg.sv | 30 +++
 rtl/spi_sclk_gen.sv | 46 ++++
 rtl/spi_cmd_controller.sv | 124 ++++++++++++
 tb/tb_spi_cmd_controller.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// ============================================================================
// spi_ctrl_pkg : shared types and constants for the SPI command controller
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam int FRAME_BITS = 16;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // Register map of the PWM peripheral's register bank
  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_DUTY        = 7'h04;

endpackage

`default_nettype wire

// File: rtl/spi_sclk_gen.sv
// ============================================================================
// spi_sclk_gen : half-period counter, SCLK register and edge strobes
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic toggle_en_i,
  output logic tick_o,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic sclk_o
);

  localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic       sclk_q;

  // tick marks the last cycle of every D-cycle half-period
  assign tick_o      = run_i && (cnt_q == LAST_CNT);
  assign sclk_rise_o = tick_o && toggle_en_i && !sclk_q;
  assign sclk_fall_o = tick_o && toggle_en_i && sclk_q;
  assign sclk_o      = sclk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 8'd0;
      sclk_q <= 1'b0;
    end else begin
      if (!run_i || tick_o) cnt_q <= 8'd0;
      else                  cnt_q <= cnt_q + 8'd1;

      if (!toggle_en_i) sclk_q <= 1'b0;
      else if (tick_o)  sclk_q <= ~sclk_q;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_cmd_controller.sv
// ============================================================================
// spi_cmd_controller : mode-0 SPI initiator for 16-bit register write/read frames
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_cmd_controller
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              sclk,
  output logic              copi,
  output logic              ncs,
  input  logic              cipo,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rsp_data
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] FIRST_RX = BIT_W'(ADDR_W + 1);

  state_e             state_q;
  logic [FRAME_W-1:0] sh_q;
  logic [BIT_W-1:0]   bit_q;
  logic [DATA_W-1:0]  rx_q;
  logic [DATA_W-1:0]  rsp_q;
  logic               rw_q;
  logic               ready_q;
  logic               ncs_q;
  logic               done_q;

  logic tick;
  logic sclk_rise;
  logic sclk_fall;
  logic sclk_w;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk         (clk),
    .rst         (rst),
    .run_i       (state_q != IDLE),
    .toggle_en_i (state_q == SHIFT),
    .tick_o      (tick),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .sclk_o      (sclk_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      rx_q    <= '0;
      rsp_q   <= '0;
      rw_q    <= 1'b0;
      ready_q <= 1'b1;
      ncs_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && ready_q) begin
            sh_q    <= {cmd_rw, cmd_addr, cmd_rw ? cmd_data : {DATA_W{1'b0}}};
            rw_q    <= cmd_rw;
            bit_q   <= '0;
            ready_q <= 1'b0;
            ncs_q   <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (sclk_rise && (rw_q == RW_READ) && (bit_q >= FIRST_RX))
            rx_q <= {rx_q[DATA_W-2:0], cipo};
          // copi is the shift register MSB, so it only moves on the falling edge
          if (sclk_fall) begin
            sh_q  <= {sh_q[FRAME_W-2:0], 1'b0};
            bit_q <= bit_q + 1'b1;
            if (bit_q == LAST_BIT) state_q <= HOLD;
          end
        end
        HOLD: begin
          if (tick) begin
            ncs_q   <= 1'b1;
            done_q  <= 1'b1;
            if (rw_q == RW_READ) rsp_q <= rx_q;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = !ready_q;
  assign sclk      = sclk_w;
  assign copi      = sh_q[FRAME_W-1];
  assign ncs       = ncs_q;
  assign done      = done_q;
  assign rsp_data  = rsp_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_controller.sv
// ============================================================================
// tb_spi_cmd_controller : directed + random frames on D=4 and D=1 instances
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_cmd_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       cmd_valid;
  logic       cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       cipo;

  logic       v4, r4, b4, sc4, co4, n4, d4;
  logic       v1, r1, b1, sc1, co1, n1, d1;
  logic [7:0] rsp4, rsp1;

  logic       o_ready, o_busy, o_sclk, o_copi, o_ncs, o_done;
  logic [7:0] o_rsp;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [7:0] exp_rsp [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign v4 = cmd_valid & ~sel;
  assign v1 = cmd_valid & sel;

  assign o_ready = sel ? r1   : r4;
  assign o_busy  = sel ? b1   : b4;
  assign o_sclk  = sel ? sc1  : sc4;
  assign o_copi  = sel ? co1  : co4;
  assign o_ncs   = sel ? n1   : n4;
  assign o_done  = sel ? d1   : d4;
  assign o_rsp   = sel ? rsp1 : rsp4;

  spi_cmd_controller #(.CLK_DIV(4), .ADDR_W(7), .DATA_W(8)) dut4 (
    .clk(clk), .rst(rst), .cmd_valid(v4), .cmd_ready(r4), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .sclk(sc4), .copi(co4), .ncs(n4),
    .cipo(cipo), .busy(b4), .done(d4), .rsp_data(rsp4)
  );

  spi_cmd_controller #(.CLK_DIV(1), .ADDR_W(7), .DATA_W(8)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(v1), .cmd_ready(r1), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .sclk(sc1), .copi(co1), .ncs(n1),
    .cipo(cipo), .busy(b1), .done(d1), .rsp_data(rsp1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one command and follows the whole frame against the timing rules.
  task automatic run_frame(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                           input logic [7:0] rbyte, input bit mangle, input logic [6:0] naddr,
                           input logic [7:0] ndata, input bit keep, output int t0);
    int d, k, rises, falls, ncs_low, done_cyc, done_cnt, ready_cyc, hi, bad_hi, bad_idle, wait_n;
    logic        prev;
    logic [15:0] fobs, fexp;
    logic [7:0]  rsp_at_done;
    d = sel ? 1 : 4;
    fexp = {rw, addr, rw ? data : 8'h00};
    cmd_rw = rw; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    cipo = 1'($urandom);
    wait_n = 0;
    while (!o_ready && wait_n < 400) begin @(posedge clk); #1; wait_n++; end
    chk("accept_wait", 32'(wait_n < 400), 32'd1);
    @(posedge clk); t0 = cyc; #1;
    if (!keep) cmd_valid = 1'b0;
    rises = 0; falls = 0; ncs_low = 0; done_cyc = 0; done_cnt = 0; ready_cyc = 0;
    hi = 0; bad_hi = 0; bad_idle = 0; prev = 1'b0; fobs = '0; rsp_at_done = 'x;
    k = 1;
    while (k <= 34 * d + 20) begin
      if (k == 5 && mangle) begin cmd_addr = naddr; cmd_data = ndata; end
      if (!o_ncs) ncs_low++;
      if (o_ncs && o_sclk) bad_idle++;
      if (o_sclk && !prev) begin rises++; fobs = {fobs[14:0], o_copi}; end
      if (o_sclk) hi++;
      if (!o_sclk && prev) begin
        falls++;
        if (hi != d) bad_hi++;
        hi = 0;
        if (falls >= 8 && falls <= 15) cipo = rbyte[15 - falls];
      end
      if (o_done) begin done_cnt++; done_cyc = k; rsp_at_done = o_rsp; end
      if (o_ready) begin ready_cyc = k; break; end
      prev = o_sclk;
      @(posedge clk); #1; k++;
    end
    if (!rw) exp_rsp[sel] = rbyte;
    chk("frame",      32'(fobs),      32'(fexp));
    chk("rises",      32'(rises),     32'd16);
    chk("ncs_low",    32'(ncs_low),   32'(33 * d));
    chk("done_cyc",   32'(done_cyc),  32'(1 + 33 * d));
    chk("done_cnt",   32'(done_cnt),  32'd1);
    chk("ready_cyc",  32'(ready_cyc), 32'(1 + 34 * d));
    chk("sclk_hi",    32'(bad_hi),    32'd0);
    chk("sclk_idle",  32'(bad_idle),  32'd0);
    chk("rsp_done",   32'(rsp_at_done), 32'(exp_rsp[sel]));
  endtask

  initial begin
    int k, t1, t2, dn;
    logic       rw;
    logic [6:0] a;
    logic [7:0] dat, rb;
    rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0;
    cmd_addr = '0; cmd_data = '0; cipo = 1'b0;
    exp_rsp[0] = '0; exp_rsp[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); #1;
      chk("rst_ncs",   32'(o_ncs),   32'd1);
      chk("rst_sclk",  32'(o_sclk),  32'd0);
      chk("rst_copi",  32'(o_copi),  32'd0);
      chk("rst_done",  32'(o_done),  32'd0);
      chk("rst_rsp",   32'(o_rsp),   32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_busy",  32'(o_busy),  32'd0);
    end
    sel = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(1'b1, 7'h02, 8'hF0, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, t1);

    // Reset landing on the edge that would raise sclk for bit 5
    cmd_rw = 1'b1; cmd_addr = 7'h07; cmd_data = 8'h99; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    k = 1;
    while (k < 11 * 4) begin @(posedge clk); #1; k++; end
    chk("pre_rst_sclk", 32'(o_sclk), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ncs",   32'(o_ncs),   32'd1);
    chk("mid_rst_sclk",  32'(o_sclk),  32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
    chk("mid_rst_busy",  32'(o_busy),  32'd0);
    rst = 1'b0;
    dn = 0;
    repeat (150) begin @(posedge clk); #1; if (o_done) dn++; end
    chk("mid_rst_nodone", 32'(dn), 32'd0);
    run_frame(1'b1, 7'h00, 8'hFF, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, t1);

    run_frame(1'b0, 7'h04, 8'h5A, 8'hA5, 1'b0, 7'h00, 8'h00, 1'b0, t1);
    run_frame(1'b1, 7'h01, 8'h77, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, t1);
    chk("rsp_hold", 32'(o_rsp), 32'h0000_00A5);

    // Back-to-back with cmd_valid held and inputs changed mid-frame
    run_frame(1'b1, 7'h03, 8'h11, 8'h00, 1'b1, 7'h05, 8'h22, 1'b1, t1);
    run_frame(1'b1, 7'h05, 8'h22, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, t2);
    chk("b2b_period", 32'(t2 - t1), 32'd137);
    chk("b2b_gap_ge4", 32'((t2 - t1 - 132) >= 4), 32'd1);

    sel = 1'b1; #1;
    run_frame(1'b1, 7'h01, 8'h3C, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, t1);

    for (int i = 0; i < 8; i++) begin
      sel = 1'($urandom); #1;
      rw  = 1'($urandom);
      a   = 7'($urandom);
      dat = 8'($urandom);
      rb  = 8'($urandom);
      run_frame(rw, a, dat, rb, 1'b0, 7'h00, 8'h00, 1'b0, t1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
